// File: rtl/fifo_uart_drain.sv
// Drains a byte FIFO onto an asynchronous serial line.
// Each byte is popped, sent as a start/8-data/[parity]/stop frame, and the next pop waits for the frame to end.
module fifo_uart_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          bit_end;

   assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
      end
   end

   // bit_q doubles as the stop-bit index once the data bits are out
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q + BW'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      fifo_rd    = 1'b0;
      tx         = 1'b1;
      busy       = (state_q != S_IDLE);
      frame_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (enable && !fifo_empty) state_d = S_POP;
         end
         S_POP: begin
            fifo_rd = 1'b1;
            baud_d  = '0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            shift_d  = fifo_data;
            parity_d = ^fifo_data;
            baud_d   = '0;
            state_d  = S_START;
         end
         S_START: begin
            tx = 1'b0;
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx = shift_q[0];
            if (bit_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = PARITY_EN ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            tx = parity_q;
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  frame_done = 1'b1;
                  bit_d      = '0;
                  state_d    = S_IDLE;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: two instances (plain 8N1 and 8E2) each fed by a small FIFO model;
// a monitor decodes serial frames and checks them against a queue of expected bytes.
module tb_fifo_uart_drain;
   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] en, we;
   logic [7:0] wd;
   logic       sel;
   logic       rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;
   logic [1:0] rd_v, tx_v, busy_v, fd_v, empty, rd_prev;
   logic [7:0] dout [2];
   logic [7:0] mem [2][16];
   logic [3:0] rp [2];
   logic [3:0] wp [2];
   logic [4:0] cnt [2];
   logic       tx_m, fd_m;

   assign rd_v   = {rd1, rd0};
   assign tx_v   = {tx1, tx0};
   assign busy_v = {busy1, busy0};
   assign fd_v   = {fd1, fd0};
   assign empty  = {cnt[1] == 5'd0, cnt[0] == 5'd0};
   assign tx_m   = sel ? tx1 : tx0;
   assign fd_m   = sel ? fd1 : fd0;

   fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(dout[0]),
      .fifo_rd(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0));

   fifo_uart_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(dout[1]),
      .fifo_rd(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1));

   // FIFO model: registered read, data valid the cycle after a read strobe
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (frst) begin
            rp[k] <= '0; wp[k] <= '0; cnt[k] <= '0; dout[k] <= '0;
         end else begin
            if (rd_v[k] && cnt[k] != 5'd0) begin
               dout[k] <= mem[k][rp[k]];
               rp[k]   <= rp[k] + 4'd1;
            end
            if (we[k]) begin
               mem[k][wp[k]] <= wd;
               wp[k]         <= wp[k] + 4'd1;
            end
            cnt[k] <= cnt[k] + 5'(we[k]) - 5'(rd_v[k] && cnt[k] != 5'd0);
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_cnt [2];
   int fd_cnt [2];
   int underflow = 0, dbl_rd = 0;
   initial begin
      rd_cnt[0] = 0; rd_cnt[1] = 0; fd_cnt[0] = 0; fd_cnt[1] = 0; rd_prev = 2'b00;
   end
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rd_v[k]) begin
            rd_cnt[k] <= rd_cnt[k] + 1;
            if (empty[k]) underflow <= underflow + 1;
            if (rd_prev[k]) dbl_rd <= dbl_rd + 1;
         end
         if (fd_v[k]) fd_cnt[k] <= fd_cnt[k] + 1;
      end
      rd_prev <= rd_v;
   end

   int total = 0, bad = 0;
   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   logic [7:0] exp_q[$];
   int         gap_q[$];
   int         last_fd_cyc = 0, last_len = 0;
   logic       last_par = 1'b0;

   // Called on the first cycle of a start bit; walks the frame cycle by cycle
   task automatic run_frame();
      int         pe = sel ? 1 : 0;
      int         nb = 9 + pe + (sel ? 2 : 1);
      int         start_cyc = cyc;
      int         lvl_err = 0, fd_err = 0;
      logic [7:0] exp_b = 8'h00;
      logic [7:0] got = 8'h00;
      logic       lvl, fd_exp;
      logic       par_s = 1'b0;
      if (exp_q.size() == 0) chk("frame_expected", 0, 1);
      else exp_b = exp_q.pop_front();
      gap_q.push_back(start_cyc - last_fd_cyc - 1);
      for (int b = 0; b < nb; b++) begin
         if (b == 0) lvl = 1'b0;
         else if (b <= 8) lvl = exp_b[b-1];
         else if (pe == 1 && b == 9) lvl = ^exp_b;
         else lvl = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) return;
            fd_exp = (b == nb - 1) && (c == CPB - 1);
            if (tx_m !== lvl) lvl_err++;
            if (fd_m !== fd_exp) fd_err++;
            if (c == CPB / 2) begin
               if (b >= 1 && b <= 8) got[b-1] = tx_m;
               if (pe == 1 && b == 9) par_s = tx_m;
            end
         end
      end
      last_fd_cyc = cyc;
      last_len    = cyc - start_cyc + 1;
      last_par    = par_s;
      chk("frame_data", int'(got), int'(exp_b));
      chk("frame_level_errs", lvl_err, 0);
      chk("frame_done_errs", fd_err, 0);
   endtask

   initial begin : monitor
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && prev && !tx_m) run_frame();
         prev = tx_m;
      end
   end

   task automatic push(input int k, input logic [7:0] b);
      @(negedge clk);
      we[k] = 1'b1;
      wd    = b;
      exp_q.push_back(b);
      @(negedge clk);
      we[k] = 1'b0;
   endtask

   task automatic wait_fd(input int k, input int target, input int bound, input string name);
      int n = 0;
      while (fd_cnt[k] < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(fd_cnt[k] >= target), 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      en = 2'b00; we = 2'b00; wd = 8'h00; sel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", int'(tx_v), 3);
      chk("rst_busy", int'(busy_v), 0);
      chk("rst_rd", int'(rd_v), 0);
      chk("rst_fd", int'(fd_v), 0);
      frst = 1'b0;
      rst  = 1'b0;

      // enable low with data waiting
      push(0, 8'hA5);
      repeat (30) @(negedge clk);
      chk("t4_gated_rd", rd_cnt[0], 0);
      chk("t4_gated_tx", int'(tx0), 1);
      chk("t4_gated_busy", int'(busy0), 0);

      // single byte 0xA5, latency to start bit
      en[0] = 1'b1;
      @(negedge clk); chk("t2_pop_rd", int'(rd0), 1);
      @(negedge clk); chk("t2_load_tx", int'(tx0), 1);
      @(negedge clk); chk("t2_start_tx", int'(tx0), 0);
      wait_fd(0, 1, 100, "t2_done");
      repeat (5) @(negedge clk);
      chk("t2_rd_pulses", rd_cnt[0], 1);
      chk("t2_fd_pulses", fd_cnt[0], 1);
      chk("t2_empty", int'(empty[0]), 1);
      chk("t2_len", last_len, 40);

      // back-to-back 0x00, 0xFF
      gap_q.delete();
      push(0, 8'h00);
      push(0, 8'hFF);
      wait_fd(0, 3, 300, "t3_done");
      repeat (5) @(negedge clk);
      chk("t3_rd_pulses", rd_cnt[0], 3);
      chk("t3_gap", (gap_q.size() == 2) ? gap_q[1] : -1, 3);

      // enable dropped mid-frame
      push(0, 8'h3C);
      push(0, 8'hC3);
      en[0] = 1'b0;
      wait_fd(0, 4, 200, "t4_done");
      repeat (60) @(negedge clk);
      chk("t4_rd_pulses", rd_cnt[0], 4);
      chk("t4_left", int'(cnt[0]), 1);
      chk("t4_busy", int'(busy0), 0);

      // reset in the middle of the data bits
      en[0] = 1'b1;
      n = 0;
      while (tx0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t1_start_seen", int'(tx0), 0);
      repeat (3 * CPB) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t1_rst_tx", int'(tx0), 1);
      chk("t1_rst_busy", int'(busy0), 0);
      chk("t1_rst_rd", int'(rd0), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("t1_idle_busy", int'(busy0), 0);
      chk("t1_rd_pulses", rd_cnt[0], 5);
      chk("t1_fd_pulses", fd_cnt[0], 4);

      // full drain of 16 bytes
      gap_q.delete();
      for (int i = 0; i < 16; i++) push(0, 8'(i));
      wait_fd(0, 20, 16 * 50 + 100, "t6_done");
      repeat (5) @(negedge clk);
      chk("t6_rd_pulses", rd_cnt[0], 21);
      chk("t6_empty", int'(empty[0]), 1);
      chk("t6_frames", gap_q.size(), 16);
      n = 0;
      for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 3) n++;
      chk("t6_gap_errs", n, 0);

      // parity and two stop bits on the second instance
      en[0] = 1'b0;
      sel   = 1'b1;
      push(1, 8'h07);
      en[1] = 1'b1;
      wait_fd(1, 1, 200, "t5_done");
      repeat (5) @(negedge clk);
      chk("t5_len", last_len, 48);
      chk("t5_parity", int'(last_par), 1);
      chk("t5_rd_pulses", rd_cnt[1], 1);

      chk("underflow", underflow, 0);
      chk("double_rd", dbl_rd, 0);
      chk("exp_left", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
